// File: rtl/arm_pkg.sv
// Shared types and constants for the data-memory SRAM controller.
// The address helper turns a CPU byte address into a 17-bit SRAM word index.
package arm_pkg;

    localparam int          SRAM_AW   = 18;
    localparam int          SRAM_DW   = 16;
    localparam logic [31:0] DATA_BASE = 32'd1024;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } sram_state_t;

    // Offset is taken mod 2^32; out-of-range addresses wrap silently.
    function automatic logic [SRAM_AW-2:0] addr_to_word(input logic [31:0] address,
                                                         input logic [31:0] base);
        return (SRAM_AW-1)'((address - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Splits one 32-bit load/store into two 16-bit asynchronous SRAM accesses
// (low halfword, then high), each lasting WAIT_CYCLES clocks.
module sram_ctrl
    import arm_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DATA_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int            CW   = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    sram_state_t      state;
    sram_state_t      next_state;
    logic [CW-1:0]    cnt;
    logic             is_write;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]      wdata_q;
    logic             req;
    logic             last;

    assign req  = wr_en | rd_en;
    assign last = (cnt == LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req)  next_state = LOW;
            LOW:     if (last) next_state = HIGH;
            HIGH:    if (last) next_state = DONE;
            DONE:              next_state = IDLE;
            default:           next_state = IDLE;
        endcase
    end

    // Wait counter, request latch and read capture; inputs are ignored after IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            is_write  <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        is_write <= wr_en;
                        word_q   <= addr_to_word(address, BASE_ADDR);
                        wdata_q  <= write_data;
                    end
                end
                LOW, HIGH: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (!is_write && last) begin
                        if (state == LOW) read_data[15:0]  <= sram_dq_in;
                        else              read_data[31:16] <= sram_dq_in;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        ready       = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_addr   = {word_q, state == HIGH};
        sram_dq_out = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
        case (state)
            IDLE: ready = ~req;
            LOW, HIGH: begin
                if (is_write) begin
                    sram_dq_oe = 1'b1;
                    // Releasing WE on the final cycle gives the rising edge that commits data.
                    sram_we_n  = last;
                end else begin
                    sram_oe_n  = 1'b0;
                end
            end
            DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM, word-level reference memory and
// per-cycle protocol expectations derived from the phase/wait-state rules.
module tb_sram_ctrl;
    import arm_pkg::*;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sram [0:262143];
    logic [31:0] ref_words [int];
    logic [31:0] exp_rd;

    sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: data appears while OE is low, writes land on the rising WE edge.
    assign sram_dq_in = sram_oe_n ? 16'hDEAD : sram[sram_addr];
    always @(posedge sram_we_n) if (sram_dq_oe === 1'b1) sram[sram_addr] <= sram_dq_out;

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[18:2];
    endfunction

    function automatic logic [31:0] ref_read(input logic [16:0] w);
        if (ref_words.exists(int'(w))) return ref_words[int'(w)];
        return 32'h0;
    endfunction

    // One complete access starting now (just after a rising edge); request held through DONE.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        logic [16:0] w;
        bit          exp_ready;
        bit          h;
        int          p;
        logic [15:0] half;
        w = word_of(a);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        for (int c = 0; c <= 2*W+1; c++) begin
            @(negedge clk);
            exp_ready = (c == 2*W+1);
            h = (c > W);
            p = (c - 1) % W;
            half = h ? d[31:16] : d[15:0];
            checks++;
            if (ready !== exp_ready) begin
                failures++;
                $display("FAIL %s c%0d ready got=%b exp=%b", tag, c, ready, exp_ready);
            end
            if (c >= 1 && c <= 2*W) begin
                checks++;
                if (sram_addr !== {w, h}) begin
                    failures++;
                    $display("FAIL %s c%0d sram_addr got=%h exp=%h", tag, c, sram_addr, {w, h});
                end
                if (wr) begin
                    checks++;
                    if (sram_dq_oe !== 1'b1 || sram_oe_n !== 1'b1 || sram_we_n !== (p == W-1)
                        || sram_dq_out !== half) begin
                        failures++;
                        $display("FAIL %s c%0d write strobes oe=%b oe_n=%b we_n=%b dq=%h exp we_n=%b dq=%h",
                                 tag, c, sram_dq_oe, sram_oe_n, sram_we_n, sram_dq_out, p == W-1, half);
                    end
                end else begin
                    checks++;
                    if (sram_dq_oe !== 1'b0 || sram_oe_n !== 1'b0 || sram_we_n !== 1'b1) begin
                        failures++;
                        $display("FAIL %s c%0d read strobes oe=%b oe_n=%b we_n=%b exp 0/0/1",
                                 tag, c, sram_dq_oe, sram_oe_n, sram_we_n);
                    end
                end
                // The controller must ignore input changes after the latch cycle.
                address = $urandom; write_data = $urandom;
            end else begin
                checks++;
                if (sram_dq_oe !== 1'b0 || sram_oe_n !== 1'b1 || sram_we_n !== 1'b1) begin
                    failures++;
                    $display("FAIL %s c%0d idle strobes oe=%b oe_n=%b we_n=%b exp 0/1/1",
                             tag, c, sram_dq_oe, sram_oe_n, sram_we_n);
                end
            end
            if (c == 2*W+1) begin
                if (!wr) exp_rd = ref_read(w);
                checks++;
                if (read_data !== exp_rd) begin
                    failures++;
                    $display("FAIL %s read_data got=%h exp=%h", tag, read_data, exp_rd);
                end
            end
        end
        if (wr) ref_words[int'(w)] = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
                failures++;
                $display("FAIL idle ready=%b we_n=%b oe_n=%b dq_oe=%b exp 1/1/1/0",
                         ready, sram_we_n, sram_oe_n, sram_dq_oe);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0
            || read_data !== 32'h0 || sram_addr !== 18'h0) begin
            failures++;
            $display("FAIL %s ready=%b we_n=%b oe_n=%b dq_oe=%b rd=%h addr=%h exp 1/1/1/0/0/0",
                     tag, ready, sram_we_n, sram_oe_n, sram_dq_oe, read_data, sram_addr);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        exp_rd = 32'h0;
        #12;
        check_reset_outputs("reset_por");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read_basic;
        access(1'b1, 1'b0, 32'd1024, 32'h0000_2000, "wr1024");
        idle(2);
        access(1'b0, 1'b1, 32'd1024, 32'h0, "rd1024");
        idle(1);
        access(1'b1, 1'b0, 32'd1028, 32'hC000_0000, "wr1028");
        idle(1);
        access(1'b0, 1'b1, 32'd1028, 32'h0, "rd1028");
        idle(1);
    endtask

    task automatic test_both_enables;
        access(1'b1, 1'b1, 32'd1032, 32'h8000_0000, "both1032");
        idle(1);
        access(1'b0, 1'b1, 32'd1032, 32'h0, "rd1032");
        idle(1);
    endtask

    task automatic test_reset_mid;
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1036; write_data = 32'h1234_5678;
        // Stop in the last HIGH cycle: both halves are already committed.
        for (int c = 0; c <= 2*W; c++) @(negedge clk);
        #1; wr_en = 1'b0; rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        exp_rd = 32'h0;
        ref_words[int'(word_of(32'd1036))] = 32'h1234_5678;
        #1; rst = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'd1036, 32'h0, "rd1036_after_reset");
        idle(1);
    endtask

    task automatic test_back_to_back;
        access(1'b1, 1'b0, 32'd1100, 32'hA5A5_5A5A, "b2b_wr0");
        access(1'b1, 1'b0, 32'd1104, 32'h0F0F_F0F0, "b2b_wr1");
        access(1'b0, 1'b1, 32'd1100, 32'h0, "b2b_rd0");
        access(1'b0, 1'b1, 32'd1104, 32'h0, "b2b_rd1");
        idle(1);
    endtask

    task automatic test_random;
        logic [31:0] a;
        bit          wr;
        int          gap;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            wr = ($urandom_range(0, 1) == 1);
            access(wr, wr ? ($urandom_range(0, 1) == 1) : 1'b1, a, $urandom, "rand");
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_write_read_basic();
        test_both_enables();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Multi-cycle controller between the MEM stage and an off-chip 16-bit asynchronous SRAM holding data memory.
- Converts one 32-bit load/store into two sequenced 16-bit SRAM accesses, inserting wait states.
- Drives `ready`; the hazard/freeze logic inverts it to freeze IF/ID/EX/MEM until the access completes.

Parameters:
- WAIT_CYCLES, 2, cycles per halfword phase; legal range >= 2.
- BASE_ADDR, 32'd1024, byte address mapped to SRAM word 0.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- wr_en  input  1  store request from MEM stage; held until ready=1
- rd_en  input  1  load request from MEM stage; held until ready=1
- address  input  32  byte address from ALU; bits [1:0] ignored
- write_data  input  32  store data
- read_data  output  32  load data; valid in DONE cycle, held until next read completes
- ready  output  1  1 = no access pending or access completing this cycle
- sram_addr  output  18  SRAM halfword address
- sram_dq_out  output  16  data to SRAM
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the bus
- sram_dq_in  input  16  data from SRAM
- sram_we_n  output  1  active-low write strobe
- sram_oe_n  output  1  active-low output enable; 0 during read phases

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, read_data=0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - ready=1.
  - Reset during any state aborts the access immediately; no partial-write recovery.
- Request: req = wr_en | rd_en. If both are asserted, the access is a write and rd_en is ignored.
- Address mapping:
  - off = address - BASE_ADDR, mod 2^32.
  - word = off[18:2].
  - sram_addr = {word[16:0], h}, where h=0 in the LOW phase and h=1 in the HIGH phase.
  - Out-of-range addresses wrap silently; no error signal.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE:
    - ready = ~req.
    - If req: latch op (write if wr_en), word, and write_data; cnt=0; go to LOW.
  - LOW:
    - Counts WAIT_CYCLES cycles.
    - Read: sram_oe_n=0. On the last cycle (cnt=WAIT_CYCLES-1), capture sram_dq_in into read_data[15:0].
    - Write: sram_dq_oe=1, sram_dq_out=wdata[15:0], sram_we_n=0 on every cycle except the last (rising WE edge commits data).
    - Then cnt=0 and go to HIGH.
  - HIGH: same as LOW using h=1, bits [31:16], and read_data[31:16]. Then go to DONE.
  - DONE:
    - ready=1 for exactly one cycle; strobes inactive.
    - Unconditionally return to IDLE.
    - The pipeline advances on this edge.
    - A request present in the following IDLE cycle is a new access.
- Latency:
  - Request seen in cycle 0 → DONE in cycle 2*WAIT_CYCLES+1.
  - ready low for 2*WAIT_CYCLES+1 cycles (5 for the default).
- Outputs other than `ready` are registered or state-decoded; `ready` is combinational in IDLE only.
- Input changes after the IDLE latch are ignored.
- In read phases sram_we_n stays 1. Strobes are never active in IDLE or DONE.

Decomposition:
- Shared package (arm_pkg):
  - sram_state_t enum {IDLE, LOW, HIGH, DONE}.
  - SRAM_AW=18, SRAM_DW=16.
  - Default DATA_BASE=1024.
- Single module; wait counter and datapath latch are inline. No sub-module is warranted.

Test Plan:
- Reset: rst=0 mid-run → ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, read_data=0 immediately, without a clock edge.
- Write 1024 ← 32'h00002000, WAIT=2:
  - ready=0 for cycles 0–4, ready=1 in cycle 5.
  - sram_addr=0 in cycles 1–2, then 1 in cycles 3–4.
  - sram_dq_out = 16'h2000, then 16'h0000.
  - sram_we_n=0 only in cycles 1 and 3.
- Read 1024 with an SRAM model preloaded from the previous write → read_data=32'h00002000 in the DONE cycle; sram_we_n stays 1 throughout.
- Write then read at 1028 with 32'hC0000000 → sram_addr 2 then 3; halves 16'h0000, 16'hC000; read returns 32'hC0000000.
- wr_en=1 and rd_en=1 together, address 1032, data 32'h80000000 → write performed (we_n pulses), read_data unchanged.
- Reset pulse during HIGH of a write to 1036 → IDLE immediately, strobes released. A subsequent read of 1036 completes in 6 cycles with ready behaviour identical to the read test above.
